// File: rtl/ysyx_22041412_axi_pkg.sv
// Shared encodings for the AXI4 master: FSM states, burst/size codes and
// the client byte-mask to AXI size conversion.
package ysyx_22041412_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ADDR  = 2'd1,
        R_DATA  = 2'd2,
        R_DRAIN = 2'd3
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B = 3'd3;

    // Contiguous low-aligned byte masks map to their AXI size; anything else is a full word.
    function automatic logic [2:0] mask_to_size(input logic [7:0] mask);
        logic [2:0] size;
        case (mask)
            8'h01:   size = AXI_SIZE_1B;
            8'h03:   size = AXI_SIZE_2B;
            8'h0F:   size = AXI_SIZE_4B;
            default: size = AXI_SIZE_8B;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/ysyx_22041412_axi_align.sv
// Byte-lane alignment: places write mask/data onto the lanes selected by the
// address offset, and brings single-beat read data back down to lane 0.
module ysyx_22041412_axi_align
    import ysyx_22041412_axi_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OFF_W  = 3
) (
    input  logic [OFF_W-1:0]    w_off_i,
    input  logic [7:0]          w_mask_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic [OFF_W-1:0]    r_off_i,
    input  logic                r_single_i,
    input  logic [DATA_W-1:0]   r_data_i,
    output logic [DATA_W/8-1:0] w_strb_o,
    output logic [DATA_W-1:0]   w_data_o,
    output logic [DATA_W-1:0]   r_data_o
);

    localparam int STRB_W = DATA_W / 8;

    logic [STRB_W-1:0] mask_ext_s;

    assign mask_ext_s = STRB_W'(w_mask_i);

    // Write lanes: strobe bits that spill past the top lane are dropped.
    always_comb begin
        w_strb_o = mask_ext_s << w_off_i;
        w_data_o = w_data_i << {w_off_i, 3'b000};
    end

    // Bursts are word-aligned by the client, so only single beats are shifted.
    always_comb begin
        if (r_single_i) begin
            r_data_o = r_data_i >> {r_off_i, 3'b000};
        end else begin
            r_data_o = r_data_i;
        end
    end

endmodule

// File: rtl/ysyx_22041412_axi_master.sv
// AXI4 master bridging a simple client read/write port; the read and write
// engines are independent FSMs and may be active at the same time.
module ysyx_22041412_axi_master
    import ysyx_22041412_axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    // client read port
    input  logic                        r_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   r_addr_i,
    input  logic [7:0]                  r_size_i,
    input  logic [7:0]                  r_len_i,
    output logic                        r_ready_o,
    output logic [AXI_DATA_WIDTH-1:0]   data_read_o,
    output logic                        r_last_i,
    // client write port
    input  logic                        w_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   w_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   rw_w_data_i,
    input  logic [7:0]                  w_size_i,
    input  logic [7:0]                  w_len_i,
    output logic                        w_ready_o,
    output logic                        w_last_i,
    // AXI AR
    output logic                        axi_ar_valid,
    input  logic                        axi_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
    output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
    output logic [7:0]                  axi_ar_len,
    output logic [2:0]                  axi_ar_size,
    output logic [1:0]                  axi_ar_burst,
    // AXI R
    input  logic                        axi_r_valid,
    output logic                        axi_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
    input  logic [1:0]                  axi_r_resp,
    input  logic                        axi_r_last,
    input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
    // AXI AW
    output logic                        axi_aw_valid,
    input  logic                        axi_aw_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
    output logic [7:0]                  axi_aw_len,
    output logic [2:0]                  axi_aw_size,
    output logic [1:0]                  axi_aw_burst,
    // AXI W
    output logic                        axi_w_valid,
    input  logic                        axi_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
    output logic                        axi_w_last,
    // AXI B
    input  logic                        axi_b_valid,
    output logic                        axi_b_ready,
    input  logic [1:0]                  axi_b_resp,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    r_state_e                  r_state_q;
    logic                      ar_valid_q;
    logic                      r_rdy_q;
    logic                      r_abort_q;
    logic [AXI_ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]                r_len_q;
    logic [2:0]                ar_size_q;

    w_state_e                  w_state_q;
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      b_ready_q;
    logic                      w_ready_q;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]                w_len_q;
    logic [7:0]                beat_q;
    logic [2:0]                aw_size_q;
    logic [STRB_W-1:0]         w_strb_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;

    logic                      r_hs_s;
    logic                      w_last_s;
    logic                      aw_done_s;
    logic                      w_done_s;
    logic [STRB_W-1:0]         strb_al_s;
    logic [AXI_DATA_WIDTH-1:0] wdata_al_s;
    logic [AXI_DATA_WIDTH-1:0] rdata_al_s;
    logic                      unused_s;

    ysyx_22041412_axi_align #(
        .DATA_W (AXI_DATA_WIDTH),
        .OFF_W  (OFF_W)
    ) u_align (
        .w_off_i    (w_addr_i[OFF_W-1:0]),
        .w_mask_i   (w_size_i),
        .w_data_i   (rw_w_data_i),
        .r_off_i    (r_addr_q[OFF_W-1:0]),
        .r_single_i (r_len_q == 8'd0),
        .r_data_i   (axi_r_data),
        .w_strb_o   (strb_al_s),
        .w_data_o   (wdata_al_s),
        .r_data_o   (rdata_al_s)
    );

    // Response codes are ignored: error beats are sequenced like good ones.
    assign unused_s = ^{axi_r_resp, axi_r_id, axi_b_resp, axi_b_id};

    assign r_hs_s      = axi_r_valid && r_rdy_q;
    assign r_ready_o   = (r_state_q == R_DATA) && r_valid_i && r_hs_s;
    assign r_last_i    = r_ready_o && axi_r_last;
    assign data_read_o = rdata_al_s;

    assign axi_ar_valid = ar_valid_q;
    assign axi_ar_addr  = r_addr_q;
    assign axi_ar_id    = {AXI_ID_WIDTH{1'b0}};
    assign axi_ar_len   = r_len_q;
    assign axi_ar_size  = ar_size_q;
    assign axi_ar_burst = AXI_BURST_INCR;
    assign axi_r_ready  = r_rdy_q;

    // Read engine: request, address phase, beat delivery, and silent drain on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            ar_valid_q <= 1'b0;
            r_rdy_q    <= 1'b0;
            r_abort_q  <= 1'b0;
            r_addr_q   <= {AXI_ADDR_WIDTH{1'b0}};
            r_len_q    <= 8'd0;
            ar_size_q  <= 3'd0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (r_valid_i) begin
                        r_addr_q   <= r_addr_i;
                        r_len_q    <= r_len_i;
                        ar_size_q  <= mask_to_size(r_size_i);
                        r_abort_q  <= 1'b0;
                        ar_valid_q <= 1'b1;
                        r_state_q  <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (!r_valid_i) begin
                        r_abort_q <= 1'b1;
                    end
                    if (axi_ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_rdy_q    <= 1'b1;
                        r_state_q  <= (r_abort_q || !r_valid_i) ? R_DRAIN : R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs_s && axi_r_last) begin
                        r_rdy_q   <= 1'b0;
                        r_state_q <= R_IDLE;
                    end else if (!r_valid_i) begin
                        r_state_q <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (r_hs_s && axi_r_last) begin
                        r_rdy_q   <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    ar_valid_q <= 1'b0;
                    r_rdy_q    <= 1'b0;
                    r_state_q  <= R_IDLE;
                end
            endcase
        end
    end

    assign w_last_s  = (beat_q == w_len_q);
    assign aw_done_s = !aw_valid_q || axi_aw_ready;
    assign w_done_s  = !w_valid_q || (axi_w_ready && w_last_s);

    assign axi_aw_valid = aw_valid_q;
    assign axi_aw_addr  = w_addr_q;
    assign axi_aw_id    = {AXI_ID_WIDTH{1'b0}};
    assign axi_aw_len   = w_len_q;
    assign axi_aw_size  = aw_size_q;
    assign axi_aw_burst = AXI_BURST_INCR;
    assign axi_w_valid  = w_valid_q;
    assign axi_w_data   = w_data_q;
    assign axi_w_strb   = w_strb_q;
    assign axi_w_last   = w_valid_q && w_last_s;
    assign axi_b_ready  = b_ready_q;
    assign w_ready_o    = w_ready_q;
    assign w_last_i     = w_ready_q;

    // Write engine: AW and W complete in either order (W_ADDR = AW pending), then await B.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            w_ready_q  <= 1'b0;
            w_addr_q   <= {AXI_ADDR_WIDTH{1'b0}};
            w_len_q    <= 8'd0;
            beat_q     <= 8'd0;
            aw_size_q  <= 3'd0;
            w_strb_q   <= {STRB_W{1'b0}};
            w_data_q   <= {AXI_DATA_WIDTH{1'b0}};
        end else begin
            w_ready_q <= 1'b0;
            case (w_state_q)
                W_IDLE: begin
                    // The completion-pulse cycle is skipped so a still-high request is not re-issued.
                    if (w_valid_i && !w_ready_q) begin
                        w_addr_q   <= w_addr_i;
                        w_len_q    <= w_len_i;
                        aw_size_q  <= mask_to_size(w_size_i);
                        w_strb_q   <= strb_al_s;
                        w_data_q   <= wdata_al_s;
                        beat_q     <= 8'd0;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        w_state_q  <= W_ADDR;
                    end
                end
                W_ADDR, W_DATA: begin
                    if (aw_valid_q && axi_aw_ready) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (w_valid_q && axi_w_ready) begin
                        if (w_last_s) begin
                            w_valid_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                    if (aw_done_s && w_done_s) begin
                        b_ready_q <= 1'b1;
                        w_state_q <= W_RESP;
                    end else if (aw_done_s) begin
                        w_state_q <= W_DATA;
                    end
                end
                W_RESP: begin
                    if (axi_b_valid) begin
                        b_ready_q <= 1'b0;
                        w_ready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    b_ready_q  <= 1'b0;
                    w_state_q  <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_axi_master.sv
// Directed bench for the AXI master: the initial block plays both the client
// and the AXI slave, one clock step at a time.
module tb_ysyx_22041412_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_valid_i;
    logic [31:0] r_addr_i;
    logic [7:0]  r_size_i;
    logic [7:0]  r_len_i;
    logic        r_ready_o;
    logic [63:0] data_read_o;
    logic        r_last_i;
    logic        w_valid_i;
    logic [31:0] w_addr_i;
    logic [63:0] rw_w_data_i;
    logic [7:0]  w_size_i;
    logic [7:0]  w_len_i;
    logic        w_ready_o;
    logic        w_last_i;
    logic        axi_ar_valid, axi_ar_ready;
    logic [31:0] axi_ar_addr;
    logic [3:0]  axi_ar_id;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size;
    logic [1:0]  axi_ar_burst;
    logic        axi_r_valid, axi_r_ready;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic        axi_r_last;
    logic [3:0]  axi_r_id;
    logic        axi_aw_valid, axi_aw_ready;
    logic [31:0] axi_aw_addr;
    logic [3:0]  axi_aw_id;
    logic [7:0]  axi_aw_len;
    logic [2:0]  axi_aw_size;
    logic [1:0]  axi_aw_burst;
    logic        axi_w_valid, axi_w_ready;
    logic [63:0] axi_w_data;
    logic [7:0]  axi_w_strb;
    logic        axi_w_last;
    logic        axi_b_valid, axi_b_ready;
    logic [1:0]  axi_b_resp;
    logic [3:0]  axi_b_id;

    int checks   = 0;
    int failures = 0;
    int rpulses  = 0;
    int rhs      = 0;
    int wpulses  = 0;

    always #5 clk = ~clk;

    ysyx_22041412_axi_master dut (
        .clk(clk), .rst(rst),
        .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_size_i(r_size_i), .r_len_i(r_len_i),
        .r_ready_o(r_ready_o), .data_read_o(data_read_o), .r_last_i(r_last_i),
        .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .rw_w_data_i(rw_w_data_i),
        .w_size_i(w_size_i), .w_len_i(w_len_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
        .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
        .axi_ar_burst(axi_ar_burst),
        .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
        .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
        .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
        .axi_aw_burst(axi_aw_burst),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
        .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
        .axi_b_id(axi_b_id)
    );

    // Event counters sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (r_ready_o) rpulses <= rpulses + 1;
        if (axi_r_valid && axi_r_ready) rhs <= rhs + 1;
        if (w_ready_o) wpulses <= wpulses + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int base_p;
    int base_h;

    initial begin
        rst = 1'b1;
        r_valid_i = 1'b0; r_addr_i = 32'h0; r_size_i = 8'h0; r_len_i = 8'h0;
        w_valid_i = 1'b0; w_addr_i = 32'h0; rw_w_data_i = 64'h0; w_size_i = 8'h0; w_len_i = 8'h0;
        axi_ar_ready = 1'b0; axi_aw_ready = 1'b0; axi_w_ready = 1'b0;
        axi_r_valid = 1'b0; axi_r_data = 64'h0; axi_r_resp = 2'b00; axi_r_last = 1'b0; axi_r_id = 4'h0;
        axi_b_valid = 1'b0; axi_b_resp = 2'b00; axi_b_id = 4'h0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ar_valid", {63'd0, axi_ar_valid}, 64'd0);
        chk("rst_aw_valid", {63'd0, axi_aw_valid}, 64'd0);
        chk("rst_w_valid",  {63'd0, axi_w_valid},  64'd0);
        chk("rst_r_ready",  {63'd0, axi_r_ready},  64'd0);
        chk("rst_b_ready",  {63'd0, axi_b_ready},  64'd0);
        chk("rst_w_ready_o", {63'd0, w_ready_o},   64'd0);

        // Single 4-byte read at offset 4
        r_valid_i = 1'b1; r_addr_i = 32'h8000_0004; r_size_i = 8'h0F; r_len_i = 8'd0;
        tick();
        chk("rd1_ar_valid", {63'd0, axi_ar_valid}, 64'd1);
        chk("rd1_ar_addr",  {32'd0, axi_ar_addr},  64'h8000_0004);
        chk("rd1_ar_size",  {61'd0, axi_ar_size},  64'd2);
        chk("rd1_ar_len",   {56'd0, axi_ar_len},   64'd0);
        chk("rd1_ar_burst", {62'd0, axi_ar_burst}, 64'd1);
        chk("rd1_ar_id",    {60'd0, axi_ar_id},    64'd0);
        axi_ar_ready = 1'b1;
        tick();
        axi_ar_ready = 1'b0;
        chk("rd1_ar_drop",  {63'd0, axi_ar_valid}, 64'd0);
        chk("rd1_r_ready",  {63'd0, axi_r_ready},  64'd1);
        axi_r_valid = 1'b1; axi_r_data = 64'h1122_3344_AABB_CCDD; axi_r_last = 1'b1;
        #1;
        chk("rd1_pulse", {63'd0, r_ready_o}, 64'd1);
        chk("rd1_data",  data_read_o, 64'h0000_0000_1122_3344);
        chk("rd1_last",  {63'd0, r_last_i}, 64'd1);
        tick();
        axi_r_valid = 1'b0; axi_r_last = 1'b0; r_valid_i = 1'b0;
        #1;
        chk("rd1_after_pulse", {63'd0, r_ready_o}, 64'd0);
        chk("rd1_after_rrdy",  {63'd0, axi_r_ready}, 64'd0);
        tick();
        chk("rd1_idle", {63'd0, axi_ar_valid}, 64'd0);

        // 4-beat burst with AR held off for 3 cycles
        base_p = rpulses;
        r_valid_i = 1'b1; r_addr_i = 32'h8000_0000; r_size_i = 8'hFF; r_len_i = 8'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd2_ar_hold_valid", {63'd0, axi_ar_valid}, 64'd1);
            chk("rd2_ar_hold_addr",  {32'd0, axi_ar_addr}, 64'h8000_0000);
        end
        chk("rd2_ar_len",  {56'd0, axi_ar_len},  64'd3);
        chk("rd2_ar_size", {61'd0, axi_ar_size}, 64'd3);
        axi_ar_ready = 1'b1;
        tick();
        axi_ar_ready = 1'b0;
        axi_r_resp = 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                axi_r_valid = 1'b0;
                tick();
            end
            axi_r_valid = 1'b1; axi_r_data = 64'h0102_0304_0506_0700 + 64'(b); axi_r_last = (b == 3);
            #1;
            chk("rd2_beat_pulse", {63'd0, r_ready_o}, 64'd1);
            chk("rd2_beat_data",  data_read_o, 64'h0102_0304_0506_0700 + 64'(b));
            chk("rd2_beat_last",  {63'd0, r_last_i}, (b == 3) ? 64'd1 : 64'd0);
            tick();
        end
        axi_r_valid = 1'b0; axi_r_last = 1'b0; axi_r_resp = 2'b00; r_valid_i = 1'b0;
        #1;
        chk("rd2_pulses", 64'(rpulses - base_p), 64'd4);
        chk("rd2_r_ready_off", {63'd0, axi_r_ready}, 64'd0);

        // Single 2-byte write at offset 2, W before AW
        w_valid_i = 1'b1; w_addr_i = 32'h8000_0002; w_size_i = 8'h03; rw_w_data_i = 64'hBEEF; w_len_i = 8'd0;
        tick();
        chk("wr1_aw_valid", {63'd0, axi_aw_valid}, 64'd1);
        chk("wr1_w_valid",  {63'd0, axi_w_valid},  64'd1);
        chk("wr1_aw_addr",  {32'd0, axi_aw_addr},  64'h8000_0002);
        chk("wr1_aw_size",  {61'd0, axi_aw_size},  64'd1);
        chk("wr1_strb",     {56'd0, axi_w_strb},   64'h0C);
        chk("wr1_wdata",    axi_w_data,            64'hBEEF_0000);
        chk("wr1_wlast",    {63'd0, axi_w_last},   64'd1);
        axi_w_ready = 1'b1;
        tick();
        axi_w_ready = 1'b0;
        chk("wr1_w_done",    {63'd0, axi_w_valid},  64'd0);
        chk("wr1_aw_pend",   {63'd0, axi_aw_valid}, 64'd1);
        axi_aw_ready = 1'b1;
        tick();
        axi_aw_ready = 1'b0;
        chk("wr1_aw_done",   {63'd0, axi_aw_valid}, 64'd0);
        chk("wr1_b_ready",   {63'd0, axi_b_ready},  64'd1);
        chk("wr1_no_early",  {63'd0, w_ready_o},    64'd0);
        axi_b_valid = 1'b1; axi_b_resp = 2'b10;
        tick();
        axi_b_valid = 1'b0; axi_b_resp = 2'b00;
        chk("wr1_w_ready_o", {63'd0, w_ready_o},    64'd1);
        chk("wr1_w_last_i",  {63'd0, w_last_i},     64'd1);
        chk("wr1_b_off",     {63'd0, axi_b_ready},  64'd0);
        w_valid_i = 1'b0;
        tick();
        chk("wr1_pulse_end", {63'd0, w_ready_o},    64'd0);
        chk("wr1_no_reissue", {63'd0, axi_aw_valid}, 64'd0);

        // Abort after AR handshake: beats drained silently
        base_p = rpulses; base_h = rhs;
        r_valid_i = 1'b1; r_addr_i = 32'h8000_0100; r_size_i = 8'hFF; r_len_i = 8'd3;
        tick();
        axi_ar_ready = 1'b1;
        tick();
        axi_ar_ready = 1'b0; r_valid_i = 1'b0;
        tick();
        chk("ab_r_ready", {63'd0, axi_r_ready}, 64'd1);
        for (int b = 0; b < 4; b++) begin
            axi_r_valid = 1'b1; axi_r_data = 64'hFFFF_0000_0000_0000 + 64'(b); axi_r_last = (b == 3);
            #1;
            chk("ab_no_pulse", {63'd0, r_ready_o}, 64'd0);
            tick();
        end
        axi_r_valid = 1'b0; axi_r_last = 1'b0;
        #1;
        chk("ab_pulses", 64'(rpulses - base_p), 64'd0);
        chk("ab_beats",  64'(rhs - base_h),     64'd4);
        chk("ab_r_ready_off", {63'd0, axi_r_ready}, 64'd0);

        // Concurrent read (len 1) and write (len 1)
        base_p = rpulses;
        r_valid_i = 1'b1; r_addr_i = 32'h8000_0008; r_size_i = 8'hFF; r_len_i = 8'd1;
        w_valid_i = 1'b1; w_addr_i = 32'h8000_0010; w_size_i = 8'hFF; w_len_i = 8'd1;
        rw_w_data_i = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("cc_ar_valid", {63'd0, axi_ar_valid}, 64'd1);
        chk("cc_aw_valid", {63'd0, axi_aw_valid}, 64'd1);
        chk("cc_wdata",    axi_w_data, 64'h0123_4567_89AB_CDEF);
        chk("cc_first_nolast", {63'd0, axi_w_last}, 64'd0);
        axi_ar_ready = 1'b1; axi_aw_ready = 1'b1; axi_w_ready = 1'b1;
        tick();
        axi_ar_ready = 1'b0; axi_aw_ready = 1'b0;
        chk("cc_ar_done", {63'd0, axi_ar_valid}, 64'd0);
        chk("cc_w_beat1", {63'd0, axi_w_valid},  64'd1);
        chk("cc_w_last",  {63'd0, axi_w_last},   64'd1);
        axi_r_valid = 1'b1; axi_r_data = 64'hCAFE_0000_0000_0001; axi_r_last = 1'b0;
        #1;
        chk("cc_r_pulse", {63'd0, r_ready_o}, 64'd1);
        chk("cc_r_data",  data_read_o, 64'hCAFE_0000_0000_0001);
        tick();
        axi_w_ready = 1'b0;
        chk("cc_b_ready", {63'd0, axi_b_ready}, 64'd1);
        chk("cc_w_off",   {63'd0, axi_w_valid}, 64'd0);
        axi_r_data = 64'hCAFE_0000_0000_0002; axi_r_last = 1'b1;
        #1;
        chk("cc_r_last", {63'd0, r_last_i}, 64'd1);
        tick();
        axi_r_valid = 1'b0; axi_r_last = 1'b0; r_valid_i = 1'b0;
        axi_b_valid = 1'b1;
        tick();
        axi_b_valid = 1'b0;
        chk("cc_w_ready_o", {63'd0, w_ready_o}, 64'd1);
        chk("cc_r_pulses",  64'(rpulses - base_p), 64'd2);
        w_valid_i = 1'b0;
        tick();

        // Reset mid-burst on both engines
        r_valid_i = 1'b1; r_addr_i = 32'h8000_0200; r_size_i = 8'hFF; r_len_i = 8'd3;
        w_valid_i = 1'b1; w_addr_i = 32'h8000_0300; w_size_i = 8'hFF; w_len_i = 8'd3;
        tick();
        axi_ar_ready = 1'b1; axi_w_ready = 1'b1;
        tick();
        axi_ar_ready = 1'b0; axi_w_ready = 1'b0;
        axi_r_valid = 1'b1; axi_r_data = 64'h5A5A; axi_r_last = 1'b0;
        tick();
        axi_r_valid = 1'b0;
        rst = 1'b1; r_valid_i = 1'b0; w_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        chk("mr_ar_valid", {63'd0, axi_ar_valid}, 64'd0);
        chk("mr_aw_valid", {63'd0, axi_aw_valid}, 64'd0);
        chk("mr_w_valid",  {63'd0, axi_w_valid},  64'd0);
        chk("mr_r_ready",  {63'd0, axi_r_ready},  64'd0);
        chk("mr_b_ready",  {63'd0, axi_b_ready},  64'd0);
        chk("mr_ar_addr",  {32'd0, axi_ar_addr},  64'd0);
        chk("mr_wdata",    axi_w_data,            64'd0);
        tick();
        chk("mr_quiet", {62'd0, axi_ar_valid, axi_aw_valid}, 64'd0);

        // Clean requests after reset: byte read at offset 1, word write with strobe truncation
        r_valid_i = 1'b1; r_addr_i = 32'h8000_0001; r_size_i = 8'h01; r_len_i = 8'd0;
        w_valid_i = 1'b1; w_addr_i = 32'h8000_0006; w_size_i = 8'h0F; w_len_i = 8'd0;
        rw_w_data_i = 64'hDEAD_BEEF;
        tick();
        chk("pr_ar_valid", {63'd0, axi_ar_valid}, 64'd1);
        chk("pr_ar_size",  {61'd0, axi_ar_size},  64'd0);
        chk("pr_ar_addr",  {32'd0, axi_ar_addr},  64'h8000_0001);
        chk("pr_aw_size",  {61'd0, axi_aw_size},  64'd2);
        chk("pr_strb",     {56'd0, axi_w_strb},   64'hC0);
        chk("pr_wdata",    axi_w_data,            64'hBEEF_0000_0000_0000);
        axi_ar_ready = 1'b1;
        tick();
        axi_ar_ready = 1'b0;
        axi_r_valid = 1'b1; axi_r_data = 64'h0000_0000_0000_AB00; axi_r_last = 1'b1;
        #1;
        chk("pr_r_pulse", {63'd0, r_ready_o}, 64'd1);
        chk("pr_r_data",  data_read_o, 64'h0000_0000_0000_00AB);
        tick();
        axi_r_valid = 1'b0; axi_r_last = 1'b0; r_valid_i = 1'b0;
        w_valid_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
